// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension multiply/divide unit.
package muldiv_pkg;

  // funct3 encodings of the M-extension operations.
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  // Iteration counter width, wide enough for XLEN up to 64.
  localparam int CNT_W = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Divide/remainder ops all have funct3[2] set.
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // rs1 is read as signed for these ops (MUL low half is sign-agnostic).
  function automatic logic a_is_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is read as signed for these ops.
  function automatic logic b_is_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
//
// Handshake: a request is taken on a rising edge where valid_in && ready_out
// && !flush. ready_out is high only while the unit is idle; busy is its
// inverse and stalls the front of the pipeline. result_valid is a single-cycle
// pulse with no backpressure; result and rd_out are only meaningful while it
// is high. flush kills any in-flight op and blocks a same-cycle request.
interface muldiv_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) ();
  import muldiv_pkg::*;

  logic             valid_in;
  logic             ready_out;
  logic [2:0]       op;
  logic [XLEN-1:0]  a_in;
  logic [XLEN-1:0]  b_in;
  logic [TAG_W-1:0] rd_in;
  logic             flush;
  logic             busy;
  logic             result_valid;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] rd_out;
  state_e           dbg_state;
  logic [CNT_W-1:0] dbg_count;

  modport master (
    output valid_in, op, a_in, b_in, rd_in, flush,
    input  ready_out, busy, result_valid, result, rd_out, dbg_state, dbg_count
  );

  modport slave (
    input  valid_in, op, a_in, b_in, rd_in, flush,
    output ready_out, busy, result_valid, result, rd_out, dbg_state, dbg_count
  );

endinterface

// File: rtl/muldiv_iter_core.sv
// One iteration of the shared shift/add datapath: a shift-add multiply step
// or a restoring-divide step, both built around one XLEN+1-bit adder.
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] hi_i,       // partial product high half / partial remainder
  input  logic [XLEN-1:0] lo_i,       // multiplier bits / dividend-then-quotient bits
  input  logic [XLEN-1:0] b_i,        // multiplicand / divisor magnitude
  input  logic            div_mode_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   op1;
  logic [XLEN:0]   op2;
  logic            cin;
  logic [XLEN+1:0] sum;
  logic            ge;

  // Multiply: add multiplicand when the low multiplier bit is set, then shift
  // the whole {carry,hi,lo} right. Divide: shift remainder left by one dividend
  // bit, trial-subtract the divisor, keep the difference when no borrow.
  always_comb begin
    op1  = '0;
    op2  = '0;
    cin  = 1'b0;
    ge   = 1'b0;
    hi_o = hi_i;
    lo_o = lo_i;
    if (div_mode_i) begin
      op1 = {hi_i, lo_i[XLEN-1]};
      op2 = ~{1'b0, b_i};
      cin = 1'b1;
    end else begin
      op1 = {1'b0, hi_i};
      op2 = lo_i[0] ? {1'b0, b_i} : '0;
    end
    sum = {1'b0, op1} + {1'b0, op2} + {{(XLEN+1){1'b0}}, cin};
    if (div_mode_i) begin
      ge   = sum[XLEN+1];
      hi_o = ge ? sum[XLEN-1:0] : op1[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], ge};
    end else begin
      hi_o = sum[XLEN:1];
      lo_o = {sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit beside the execute-stage ALU.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_FAST = 0,
  parameter int TAG_W    = 5
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q;
  logic             neg_q;
  logic [XLEN-1:0]  hi_q, lo_q, b_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  result_q;
  logic [TAG_W-1:0] rd_q;

  logic             accept;
  logic             a_sext, b_sext;
  logic [XLEN-1:0]  a_abs, b_abs;
  logic             div_zero, ovf, fast, neg_acc;
  logic [XLEN-1:0]  fast_res;
  logic [2*XLEN-1:0] fa, fb, fprod;
  logic [XLEN-1:0]  hi_nx, lo_nx;
  logic [2*XLEN-1:0] mag, prod;
  logic [XLEN-1:0]  qr, qr_s, sign_res;

  assign accept = bus.valid_in && (state_q == S_IDLE) && !bus.flush;

  // Decode the incoming request: magnitudes, sign of result, and whether the
  // answer is known right away (divide special cases or the fast multiplier).
  always_comb begin
    a_sext   = a_is_signed(bus.op) & bus.a_in[XLEN-1];
    b_sext   = b_is_signed(bus.op) & bus.b_in[XLEN-1];
    a_abs    = a_sext ? -bus.a_in : bus.a_in;
    b_abs    = b_sext ? -bus.b_in : bus.b_in;
    div_zero = is_div(bus.op) && (bus.b_in == '0);
    ovf      = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
               (bus.a_in == MIN_NEG) && (bus.b_in == '1);
    fast     = is_div(bus.op) ? (div_zero || ovf) : (MUL_FAST != 0);
    // Remainder follows the dividend; everything else is sign(a) xor sign(b).
    neg_acc  = (bus.op == OP_REM) ? a_sext : (a_sext ^ b_sext);
    // Low 2*XLEN bits of the sign-extended product are exact.
    fa       = {{XLEN{a_sext}}, bus.a_in};
    fb       = {{XLEN{b_sext}}, bus.b_in};
    fprod    = fa * fb;
    fast_res = '0;
    if (is_div(bus.op)) begin
      if (div_zero) fast_res = bus.op[1] ? bus.a_in : '1;
      else          fast_res = bus.op[1] ? '0 : bus.a_in;
    end else begin
      fast_res = (bus.op == OP_MUL) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
    end
  end

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .hi_i       (hi_q),
    .lo_i       (lo_q),
    .b_i        (b_q),
    .div_mode_i (is_div(op_q)),
    .hi_o       (hi_nx),
    .lo_o       (lo_nx)
  );

  // Sign fix-up: negate the magnitude result if needed and pick the half.
  always_comb begin
    mag      = {hi_q, lo_q};
    prod     = neg_q ? -mag : mag;
    qr       = op_q[1] ? hi_q : lo_q;
    qr_s     = neg_q ? -qr : qr;
    sign_res = '0;
    if (is_div(op_q))         sign_res = qr_s;
    else if (op_q == OP_MUL)  sign_res = prod[XLEN-1:0];
    else                      sign_res = prod[2*XLEN-1:XLEN];
  end

  // Next-state and iteration counter; flush abandons any in-flight op.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = fast ? S_DONE : S_CALC;
          cnt_d   = '0;
        end
      end
      S_CALC: begin
        if (cnt_q == CNT_W'(XLEN-1)) begin
          state_d = S_SIGN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SIGN:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand latch, iteration registers and held result/tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      tag_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      if (accept) begin
        op_q  <= bus.op;
        neg_q <= neg_acc;
        hi_q  <= '0;
        lo_q  <= a_abs;
        b_q   <= b_abs;
        tag_q <= bus.rd_in;
        if (fast) begin
          result_q <= fast_res;
          rd_q     <= bus.rd_in;
        end
      end else if (state_q == S_CALC) begin
        hi_q <= hi_nx;
        lo_q <= lo_nx;
      end
      if ((state_q == S_SIGN) && !bus.flush) begin
        result_q <= sign_res;
        rd_q     <= tag_q;
      end
    end
  end

  assign bus.ready_out    = (state_q == S_IDLE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.result_valid = (state_q == S_DONE) && !bus.flush;
  assign bus.result       = result_q;
  assign bus.rd_out       = rd_q;
  assign bus.dbg_state    = state_q;
  assign bus.dbg_count    = cnt_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus light random bench for muldiv_unit (iterative 32-bit and fast 64-bit builds).
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XW  = 32;
  localparam int XW1 = 64;
  localparam int TW  = 5;

  // Clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_if #(.XLEN(XW),  .TAG_W(TW)) b0 ();
  muldiv_if #(.XLEN(XW1), .TAG_W(TW)) b1 ();

  muldiv_unit #(.XLEN(XW),  .MUL_FAST(0), .TAG_W(TW)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  muldiv_unit #(.XLEN(XW1), .MUL_FAST(1), .TAG_W(TW)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  int n_checks = 0;
  int n_fails  = 0;

  logic [TW+XW-1:0]  exp_q[$];
  logic [TW+XW1-1:0] exp1_q[$];

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model for the 32-bit build using wide native arithmetic.
  function automatic logic [31:0] ref32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb, ua, ub, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = '0;
    case (op)
      OP_MUL:    begin p = sa * sb; return p[31:0];  end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = sa / sb; p = q; return p[31:0];
      end
      OP_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        q = ua / ub; p = q; return p[31:0];
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb; p = q; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        q = ua % ub; p = q; return p[31:0];
      end
    endcase
  endfunction

  // Scoreboard monitors: pop the oldest expectation on each result pulse.
  always @(negedge clk) begin
    if (b0.result_valid === 1'b1) begin
      if (exp_q.size() == 0) check("dut0_unexpected_valid", 80'(b0.result_valid), 80'd0);
      else check("dut0_result", 80'({b0.rd_out, b0.result}), 80'(exp_q.pop_front()));
    end
    if (b1.result_valid === 1'b1) begin
      if (exp1_q.size() == 0) check("dut1_unexpected_valid", 80'(b1.result_valid), 80'd0);
      else check("dut1_result", 80'({b1.rd_out, b1.result}), 80'(exp1_q.pop_front()));
    end
  end

  // Driver: issue one op on dut0, measure latency, confirm ready the cycle after DONE.
  task automatic do_op0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat,
                        input string tag);
    int lat;
    exp_q.push_back({rd, exp_res});
    b0.op = op; b0.a_in = a; b0.b_in = b; b0.rd_in = rd; b0.valid_in = 1'b1;
    @(posedge clk); #1;
    b0.valid_in = 1'b0;
    b0.a_in = $urandom;
    b0.b_in = $urandom;
    lat = 1;
    while (b0.result_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_latency"}, 80'(lat), 80'(exp_lat));
    @(posedge clk); #1;
    check({tag, "_ready_after"}, 80'(b0.ready_out), 80'd1);
  endtask

  task automatic start_op0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    b0.op = op; b0.a_in = a; b0.b_in = b; b0.rd_in = 5'd7; b0.valid_in = 1'b1;
    @(posedge clk); #1;
    b0.valid_in = 1'b0;
  endtask

  task automatic wait_count(input int target);
    int n;
    n = 0;
    while (b0.dbg_count !== CNT_W'(target) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("wait_count_reached", 80'(b0.dbg_count), 80'(target));
  endtask

  task automatic no_result_for(input int cycles, input string tag);
    logic saw;
    saw = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (b0.result_valid !== 1'b0) saw = 1'b1;
    end
    check(tag, 80'(saw), 80'd0);
  endtask

  // Stimulus
  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          rl;

    b0.valid_in = 1'b0; b0.op = '0; b0.a_in = '0; b0.b_in = '0; b0.rd_in = '0; b0.flush = 1'b0;
    b1.valid_in = 1'b0; b1.op = '0; b1.a_in = '0; b1.b_in = '0; b1.rd_in = '0; b1.flush = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",  80'(b0.ready_out),    80'd1);
    check("rst_busy",   80'(b0.busy),         80'd0);
    check("rst_valid",  80'(b0.result_valid), 80'd0);
    check("rst_result", 80'(b0.result),       80'd0);
    check("rst_rd",     80'(b0.rd_out),       80'd0);
    check("rst_count",  80'(b0.dbg_count),    80'd0);
    check("rst_state",  80'(b0.dbg_state),    80'(S_IDLE));
    rst = 1'b0;

    // Multiply variants
    do_op0(OP_MUL,   32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 34, "mul");
    do_op0(OP_MULH,  32'd7, 32'hFFFF_FFFD, 5'd2, 32'hFFFF_FFFF, 34, "mulh");
    do_op0(OP_MULHU, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'h0000_0006, 34, "mulhu");

    // Signed/unsigned divide, tag echo
    do_op0(OP_DIV,  32'hFFFF_FFEC, 32'd6, 5'd11, 32'hFFFF_FFFD, 34, "div");
    do_op0(OP_REM,  32'hFFFF_FFEC, 32'd6, 5'd11, 32'hFFFF_FFFE, 34, "rem");
    do_op0(OP_DIVU, 32'd20,        32'd6, 5'd11, 32'd3,         34, "divu");
    do_op0(OP_REMU, 32'd20,        32'd6, 5'd11, 32'd2,         34, "remu");

    // Divide by zero and signed overflow take the one-edge path
    do_op0(OP_DIV,  32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 1, "div_by_zero");
    do_op0(OP_REMU, 32'd5, 32'd0, 5'd13, 32'd5,         1, "remu_by_zero");
    do_op0(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1, "div_ovf");
    do_op0(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0,         1, "rem_ovf");

    // Random ops against the reference model
    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      rl  = (rop[2] && (rb == 0 || (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF))) ? 1 : 34;
      do_op0(rop, ra, rb, 5'(i), ref32(rop, ra, rb), rl, "rand");
    end

    // Flush mid-calculation
    start_op0(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_count(10);
    b0.flush = 1'b1;
    @(posedge clk); #1;
    b0.flush = 1'b0;
    check("flush_ready", 80'(b0.ready_out), 80'd1);
    check("flush_state", 80'(b0.dbg_state), 80'(S_IDLE));
    no_result_for(40, "flush_no_result");

    // Request and flush together: not accepted
    b0.op = OP_DIVU; b0.a_in = 32'd99; b0.b_in = 32'd3; b0.valid_in = 1'b1; b0.flush = 1'b1;
    @(posedge clk); #1;
    b0.valid_in = 1'b0; b0.flush = 1'b0;
    check("vflush_ready", 80'(b0.ready_out), 80'd1);
    check("vflush_state", 80'(b0.dbg_state), 80'(S_IDLE));
    no_result_for(40, "vflush_no_result");

    // Reset mid-calculation
    start_op0(OP_DIV, 32'hFFFF_0000, 32'd3);
    wait_count(20);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_ready",  80'(b0.ready_out),    80'd1);
    check("midrst_busy",   80'(b0.busy),         80'd0);
    check("midrst_valid",  80'(b0.result_valid), 80'd0);
    check("midrst_result", 80'(b0.result),       80'd0);
    check("midrst_rd",     80'(b0.rd_out),       80'd0);
    check("midrst_count",  80'(b0.dbg_count),    80'd0);
    no_result_for(40, "midrst_no_result");

    // Unit recovers after the kill cases
    do_op0(OP_DIVU, 32'd100, 32'd7, 5'd21, 32'd14, 34, "divu_after");

    // 64-bit fast multiplier: latency 1, back-to-back with one-cycle gap
    exp1_q.push_back({5'd4, 64'hFFFF_FFFF_FFFF_FFFF});
    b1.op = OP_MULHSU; b1.a_in = '1; b1.b_in = 64'd2; b1.rd_in = 5'd4; b1.valid_in = 1'b1;
    @(posedge clk); #1;
    check("fast_valid_lat1", 80'(b1.result_valid), 80'd1);
    check("fast_not_ready",  80'(b1.ready_out),    80'd0);
    exp1_q.push_back({5'd9, 64'd15});
    b1.op = OP_MUL; b1.a_in = 64'd3; b1.b_in = 64'd5; b1.rd_in = 5'd9;
    @(posedge clk); #1;
    check("b2b_gap_ready", 80'(b1.ready_out),    80'd1);
    check("b2b_gap_valid", 80'(b1.result_valid), 80'd0);
    @(posedge clk); #1;
    b1.valid_in = 1'b0;
    check("b2b_valid", 80'(b1.result_valid), 80'd1);
    @(posedge clk); #1;
    check("b2b_ready_after", 80'(b1.ready_out), 80'd1);

    repeat (3) @(posedge clk);
    #1;
    check("dut0_queue_empty", 80'(exp_q.size()),  80'd0);
    check("dut1_queue_empty", 80'(exp1_q.size()), 80'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, observed no end, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle RV32M/RV64M multiply/divide unit for the 5-stage pipeline core.
- Sits beside the execute-stage ALU.
- Decode steers M-extension ops here; the core stalls fetch, decode and execute while ready_out is low.
- The result, tagged with its rd, is merged into the execute→memory pipeline register when result_valid pulses.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- MUL_FAST, 0, 1 = single-cycle registered multiplier; 0 = iterative shift-add multiply.
- TAG_W, 5, width of the destination-register tag carried through.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  operation request from execute
- ready_out  out  1  unit can accept (high only in IDLE)
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a_in  in  XLEN  rs1 value (forwarded)
- b_in  in  XLEN  rs2 value (forwarded)
- rd_in  in  TAG_W  destination tag
- flush  in  1  branch/jump kill of the in-flight op
- busy  out  1  ~ready_out, drives pipeline stall
- result_valid  out  1  one-cycle result pulse
- result  out  XLEN  result data
- rd_out  out  TAG_W  tag of result

Behaviour:
- Reset: state IDLE, ready_out=1, busy=0, result_valid=0, result=0, rd_out=0, counter=0.
- Accept: on a rising edge with valid_in && ready_out && !flush. At that edge op, operands (absolute values where signed), sign flags and tag are latched.
- States and transitions:
  - IDLE → CALC on a normal accept.
  - IDLE → DONE directly on the fast path (below) or when MUL_FAST=1.
  - CALC runs exactly XLEN iterations, counter 0..XLEN-1. One multiply iteration = one shift-add. One divide iteration = one restoring-divide bit.
  - CALC → SIGN after the last iteration. SIGN performs conditional two's-complement negation and upper/lower half select.
  - SIGN → DONE.
  - DONE → IDLE unconditionally. result_valid=1 only in DONE. There is no backpressure.
- Latency, counted in edges from the accept edge to result_valid high:
  - Iterative path: XLEN+2.
  - Fast path / MUL_FAST: 1.
  - Back-to-back ops have a minimum 1-cycle gap, because DONE is not ready.
- Multiply:
  - 2·XLEN product.
  - MUL returns the low half.
  - MULH, MULHSU and MULHU return the high half with signed×signed, signed×unsigned and unsigned×unsigned semantics respectively.
- Divide: the quotient truncates toward zero. The remainder takes the dividend's sign.
- Fast path, resolved at accept:
  - Divide by zero: DIV/DIVU result = all ones; REM/REMU result = a_in.
  - Signed overflow (a_in = -2^(XLEN-1), b_in = -1): DIV result = a_in; REM result = 0.
- Flush:
  - In CALC, SIGN or DONE: next state is IDLE and result_valid is forced 0 in that cycle and after.
  - flush && valid_in in the same cycle: flush wins and the op is not accepted.
- rst mid-operation: returns to IDLE with all outputs at their reset values; no result is emitted.
- Outputs result and rd_out hold their last value outside DONE. Consumers qualify them with result_valid.
- Operand changes on a_in/b_in after the accept edge have no effect.

Decomposition:
- Shared package muldiv_pkg holds:
  - op localparams (OP_MUL..OP_REMU);
  - state encoding (S_IDLE, S_CALC, S_SIGN, S_DONE);
  - helper function is_div(op).
- One sub-module is natural: muldiv_iter_core. It is the shared XLEN+1-bit adder/shift datapath, and the top-level FSM selects add-mode (multiply) or subtract-and-restore (divide).

Test Plan (XLEN=32 unless noted):
1. MUL and MULHU, a=7, b=0xFFFFFFFD → MUL result 0xFFFFFFEB; MULH with same operands → 0xFFFFFFFF; MULHU → 0x00000006. result_valid rises 34 edges after accept.
2. Signed and unsigned divide:
   - DIV a=0xFFFFFFEC (-20), b=6 → 0xFFFFFFFD.
   - REM same operands → 0xFFFFFFFE.
   - DIVU 20/6 → 3.
   - REMU 20/6 → 2.
   - rd_out echoes rd_in=5'd11.
3. Divide by zero: DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5. result_valid one edge after accept, and ready_out returns high the next cycle.
4. Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
5. Kill cases:
   - flush asserted at counter=10 → no result_valid ever, ready_out=1 on the next cycle.
   - valid_in+flush together → not accepted.
   - rst at counter=20 → all outputs at reset values next cycle.
6. MUL_FAST=1, XLEN=64: MULHSU a=-1, b=2 → 0xFFFFFFFFFFFFFFFF with latency 1. A back-to-back request is accepted on the cycle after DONE.
